// File: rtl/sat_event_counter_pkg.sv
// sat_event_counter_pkg: shared button FSM state encodings and count width
package sat_event_counter_pkg;
  localparam int CNT_W = 5;
  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} btn_state_e;
endpackage

// File: rtl/sat_event_counter_rise_edge_det.sv
// rise_edge_det: optional 2-flop synchronizer plus IDLE/HELD FSM emitting one pulse per press
module rise_edge_det
  import sat_event_counter_pkg::*;
#(
  parameter int SYNC_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse
);
  btn_state_e r_state;
  btn_state_e w_next;
  logic w_sync;
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic r_s1;
      logic r_s2;
      // two-flop synchronizer; reset flushes any sample still in flight
      always_ff @(posedge clk or posedge rst)
        if (rst) {r_s2, r_s1} <= 2'b00;
        else {r_s2, r_s1} <= {r_s1, i_raw};
      assign w_sync = r_s2;
    end else begin : g_bypass
      assign w_sync = i_raw;
    end
  endgenerate
  // state register remembers the previous synchronized level
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // pulse only on the IDLE->HELD transition so a held button counts once
  always_comb begin
    w_next = w_sync ? HELD : IDLE;
    o_pulse = w_sync && (r_state == IDLE);
  end
endmodule

// File: rtl/sat_event_counter.sv
// sat_event_counter: up/down button counter with sticky flags; SAT_EVENT_COUNTER_SATURATE_EN selects saturate vs wrap
module sat_event_counter
  import sat_event_counter_pkg::*;
#(
  parameter int MAX     = 31,
  parameter int SYNC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_raw,
  input  logic             dec_raw,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX);
`ifdef SAT_EVENT_COUNTER_SATURATE_EN
  localparam logic [CNT_W-1:0] PAST_TOP = CMAX;
  localparam logic [CNT_W-1:0] PAST_BOT = '0;
`else
  localparam logic [CNT_W-1:0] PAST_TOP = '0;
  localparam logic [CNT_W-1:0] PAST_BOT = CMAX;
`endif
  logic [CNT_W-1:0] r_count;
  logic r_ovf;
  logic r_unf;
  logic w_inc;
  logic w_dec;
  logic w_up;
  logic w_dn;
  logic w_at_max;
  logic w_at_zero;
  logic [CNT_W-1:0] w_count_nxt;
  rise_edge_det #(.SYNC_EN(SYNC_EN)) u_inc (.clk(clk), .rst(rst), .i_raw(inc_raw), .o_pulse(w_inc));
  rise_edge_det #(.SYNC_EN(SYNC_EN)) u_dec (.clk(clk), .rst(rst), .i_raw(dec_raw), .o_pulse(w_dec));
  assign w_up = w_inc && !w_dec;
  assign w_dn = w_dec && !w_inc;
  assign w_at_max = r_count == CMAX;
  assign w_at_zero = r_count == '0;
  assign w_count_nxt = w_up ? (w_at_max ? PAST_TOP : r_count + CNT_W'(1))
                     : w_dn ? (w_at_zero ? PAST_BOT : r_count - CNT_W'(1))
                     : r_count;
  // count and sticky flags; clear overrides any pulse in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf <= r_ovf || (w_up && w_at_max);
      r_unf <= r_unf || (w_dn && w_at_zero);
    end
  assign count = r_count;
  assign ovf = r_ovf;
  assign unf = r_unf;
endmodule
